// File: rtl/lbist_sequencer_if.sv
// Handshake bundle between the LBIST sequencer (master) and the BIST datapath (slave).
// The abort input exists only when LBIST_SEQ_ABORT_EN is defined.
interface lbist_sequencer_if #(
  parameter int unsigned SEEDS     = 10,
  parameter int unsigned MISR_SIZE = 16
);
  localparam int unsigned SEED_W = (SEEDS > 1) ? $clog2(SEEDS) : 1;

  logic                 start;
  logic [MISR_SIZE-1:0] misr_sig;
`ifdef LBIST_SEQ_ABORT_EN
  logic                 abort;
`endif
  logic                 lfsr_load;
  logic [SEED_W-1:0]    seed_idx;
  logic                 lfsr_en;
  logic                 misr_clear;
  logic                 misr_en;
  logic                 test_mode;
  logic                 lbist_en;
  logic                 test_en;
  logic                 busy;
  logic                 done;
  logic                 go_nogo;

  modport master (
`ifdef LBIST_SEQ_ABORT_EN
    input  abort,
`endif
    input  start, misr_sig,
    output lfsr_load, seed_idx, lfsr_en, misr_clear, misr_en, test_mode,
    output lbist_en, test_en, busy, done, go_nogo
  );

  modport slave (
`ifdef LBIST_SEQ_ABORT_EN
    output abort,
`endif
    output start, misr_sig,
    input  lfsr_load, seed_idx, lfsr_en, misr_clear, misr_en, test_mode,
    input  lbist_en, test_en, busy, done, go_nogo
  );
endinterface

// File: rtl/lbist_sequencer.sv
// Logic-BIST control FSM: seed/pattern schedule, chain flush and MISR signature verdict.
// Optional feature: define LBIST_SEQ_ABORT_EN to add an abort input that cancels a run.
module lbist_sequencer #(
  parameter int unsigned          SEEDS     = 10,
  parameter int unsigned          LOOPS     = 200,
  parameter int unsigned          SCAN_LEN  = 24,
  parameter int unsigned          MISR_SIZE = 16,
  parameter logic [MISR_SIZE-1:0] MISR_GOLD = MISR_SIZE'(13984)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  lbist_sequencer_if.master  bus
);
  localparam int unsigned SEED_W = (SEEDS > 1) ? $clog2(SEEDS) : 1;
  localparam int unsigned SHW    = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
  localparam int unsigned LPW    = $clog2(LOOPS + 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StShift, StCapture, StUnload, StCompare, StDone
  } state_e;

  state_e            r_state, w_state_next;
  logic [SHW-1:0]    r_shift_cnt, w_shift_next;
  logic [LPW-1:0]    r_loop_cnt, w_loop_next, w_loop_inc;
  logic [SEED_W-1:0] r_seed_idx, w_seed_next;
  logic              r_go_nogo, w_go_next;
  logic              w_shift_last;
  logic              w_busy;

  assign w_shift_last = (r_shift_cnt == SHW'(SCAN_LEN - 1));
  assign w_loop_inc   = r_loop_cnt + LPW'(1);
  assign w_busy       = (r_state != StIdle) && (r_state != StDone);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_shift_cnt <= '0;
      r_loop_cnt  <= '0;
      r_seed_idx  <= '0;
      r_go_nogo   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift_cnt <= w_shift_next;
      r_loop_cnt  <= w_loop_next;
      r_seed_idx  <= w_seed_next;
      r_go_nogo   <= w_go_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift_cnt;
    w_loop_next  = r_loop_cnt;
    w_seed_next  = r_seed_idx;
    w_go_next    = r_go_nogo;
    unique case (r_state)
      StIdle, StDone: begin
        w_seed_next  = '0;
        w_shift_next = '0;
        w_loop_next  = '0;
        if (bus.start) begin
          w_state_next = StLoad;
          w_go_next    = 1'b0;
        end
      end
      StLoad: begin
        w_state_next = StShift;
        w_shift_next = '0;
        w_loop_next  = '0;
      end
      StShift: begin
        if (w_shift_last) begin
          w_state_next = StCapture;
          w_shift_next = '0;
        end else begin
          w_shift_next = r_shift_cnt + SHW'(1);
        end
      end
      StCapture: begin
        w_loop_next = w_loop_inc;
        if (w_loop_inc < LPW'(LOOPS)) begin
          w_state_next = StShift;
        end else if (r_seed_idx < SEED_W'(SEEDS - 1)) begin
          w_seed_next  = r_seed_idx + SEED_W'(1);
          w_state_next = StLoad;
        end else begin
          w_state_next = StUnload;
        end
      end
      StUnload: begin
        if (w_shift_last) begin
          w_state_next = StCompare;
          w_shift_next = '0;
        end else begin
          w_shift_next = r_shift_cnt + SHW'(1);
        end
      end
      StCompare: begin
        w_go_next    = (bus.misr_sig == MISR_GOLD);
        w_seed_next  = '0;
        w_state_next = StDone;
      end
      default: w_state_next = StIdle;
    endcase
`ifdef LBIST_SEQ_ABORT_EN
    // Abort only cancels a run in progress; in IDLE/DONE start keeps priority.
    if (w_busy && bus.abort) begin
      w_state_next = StIdle;
      w_shift_next = '0;
      w_loop_next  = '0;
      w_seed_next  = '0;
      w_go_next    = 1'b0;
    end
`endif
  end

  always_comb begin
    bus.lfsr_load  = 1'b0;
    bus.lfsr_en    = 1'b0;
    bus.misr_clear = 1'b0;
    bus.misr_en    = 1'b0;
    bus.test_mode  = 1'b0;
    bus.lbist_en   = w_busy;
    case (r_state)
      StLoad: begin
        bus.lfsr_load  = 1'b1;
        bus.misr_clear = (r_seed_idx == '0);
      end
      StShift: begin
        bus.test_mode = 1'b1;
        bus.lfsr_en   = 1'b1;
        // First pass of seed 0 unloads functional-mode state, so keep it out of the MISR.
        bus.misr_en   = !((r_seed_idx == '0) && (r_loop_cnt == '0));
      end
      StUnload: begin
        bus.test_mode = 1'b1;
        bus.misr_en   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.seed_idx = r_seed_idx;
  assign bus.test_en  = bus.lbist_en;
  assign bus.busy     = w_busy;
  assign bus.done     = (r_state == StDone);
  assign bus.go_nogo  = r_go_nogo;
endmodule

// File: tb/tb_lbist_sequencer.sv
// Self-checking bench for lbist_sequencer: schedule-derived trace model, vector table,
// randomized runs, reset/hold/abort corner sequences.
module tb_lbist_sequencer;
  localparam int unsigned SEEDS    = 2;
  localparam int unsigned LOOPS    = 3;
  localparam int unsigned SCAN_LEN = 4;
  localparam int unsigned MSZ      = 16;
  localparam logic [15:0] GOLD     = 16'd13984;
  localparam int unsigned SW       = (SEEDS > 1) ? $clog2(SEEDS) : 1;
  localparam int          RUN_LEN  = SEEDS * (1 + LOOPS * (SCAN_LEN + 1)) + SCAN_LEN + 1;

  typedef struct packed {
    logic          lfsr_load;
    logic [SW-1:0] seed_idx;
    logic          lfsr_en;
    logic          misr_clear;
    logic          misr_en;
    logic          test_mode;
    logic          lbist_en;
    logic          test_en;
    logic          busy;
    logic          done;
    logic          go_nogo;
  } out_t;

  typedef struct {
    logic [15:0] sig;
    logic        exp_go;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  out_t exp_q[$];

  always #5 clk = ~clk;

  lbist_sequencer_if #(.SEEDS(SEEDS), .MISR_SIZE(MSZ)) bus ();

  lbist_sequencer #(
    .SEEDS     (SEEDS),
    .LOOPS     (LOOPS),
    .SCAN_LEN  (SCAN_LEN),
    .MISR_SIZE (MSZ),
    .MISR_GOLD (GOLD)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  function automatic out_t sample();
    out_t o;
    o.lfsr_load  = bus.lfsr_load;
    o.seed_idx   = bus.seed_idx;
    o.lfsr_en    = bus.lfsr_en;
    o.misr_clear = bus.misr_clear;
    o.misr_en    = bus.misr_en;
    o.test_mode  = bus.test_mode;
    o.lbist_en   = bus.lbist_en;
    o.test_en    = bus.test_en;
    o.busy       = bus.busy;
    o.done       = bus.done;
    o.go_nogo    = bus.go_nogo;
    return o;
  endfunction

  task automatic chk_out(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected per-cycle outputs of one run, built directly from the seed/pattern schedule.
  task automatic build_trace();
    out_t e;
    exp_q.delete();
    for (int s = 0; s < SEEDS; s++) begin
      e = '0; e.lfsr_load = 1'b1; e.seed_idx = SW'(s); e.misr_clear = (s == 0);
      e.lbist_en = 1'b1; e.test_en = 1'b1; e.busy = 1'b1;
      exp_q.push_back(e);
      for (int l = 0; l < LOOPS; l++) begin
        for (int k = 0; k < SCAN_LEN; k++) begin
          e = '0; e.seed_idx = SW'(s); e.test_mode = 1'b1; e.lfsr_en = 1'b1;
          e.misr_en = !(s == 0 && l == 0);
          e.lbist_en = 1'b1; e.test_en = 1'b1; e.busy = 1'b1;
          exp_q.push_back(e);
        end
        e = '0; e.seed_idx = SW'(s); e.lbist_en = 1'b1; e.test_en = 1'b1; e.busy = 1'b1;
        exp_q.push_back(e);
      end
    end
    for (int k = 0; k < SCAN_LEN; k++) begin
      e = '0; e.seed_idx = SW'(SEEDS - 1); e.test_mode = 1'b1; e.misr_en = 1'b1;
      e.lbist_en = 1'b1; e.test_en = 1'b1; e.busy = 1'b1;
      exp_q.push_back(e);
    end
    e = '0; e.seed_idx = SW'(SEEDS - 1); e.lbist_en = 1'b1; e.test_en = 1'b1; e.busy = 1'b1;
    exp_q.push_back(e);
  endtask

  // Entered and left just after a falling edge.
  task automatic run_check(input logic [15:0] sig, input logic exp_go, input bit hold,
                           input bit rnd_start, input string name);
    out_t act, e;
    int n_load = 0, n_clr = 0, n_busy = 0, n_warm = 0, n_cap_tm = 0;
    bus.start = 1'b1;
    for (int i = 0; i < RUN_LEN; i++) begin
      @(posedge clk); #1;
      bus.misr_sig = (i == RUN_LEN - 1) ? sig : 16'($urandom);
      if (!hold) bus.start = rnd_start ? 1'($urandom) : 1'b0;
      @(negedge clk);
      act = sample();
      chk_out($sformatf("%s cyc%0d", name, i), act, exp_q[i]);
      n_load += int'(act.lfsr_load);
      n_clr  += int'(act.misr_clear);
      n_busy += int'(act.busy);
      if (act.test_mode && act.lfsr_en && !act.misr_en) n_warm++;
      if (act.busy && !act.lfsr_load && !act.lfsr_en && !act.misr_en && act.test_mode) n_cap_tm++;
    end
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    @(negedge clk);
    e = '0; e.done = 1'b1; e.go_nogo = exp_go;
    chk_out({name, " done"}, sample(), e);
    chk_int({name, " lfsr_load pulses"}, n_load, SEEDS);
    chk_int({name, " misr_clear pulses"}, n_clr, 1);
    chk_int({name, " busy cycles"}, n_busy, RUN_LEN);
    chk_int({name, " warm-up shifts"}, n_warm, SCAN_LEN);
    chk_int({name, " capture test_mode"}, n_cap_tm, 0);
  endtask

  task automatic run_partial(input int n, input string name);
    bus.start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.misr_sig = 16'($urandom);
      bus.start = 1'b0;
      @(negedge clk);
      chk_out($sformatf("%s cyc%0d", name, i), sample(), exp_q[i]);
    end
  endtask

  initial begin
    vec_t vecs[5];
    logic [15:0] sig;
    vecs[0] = '{GOLD,            1'b1, "pass"};
    vecs[1] = '{GOLD ^ 16'h0001, 1'b0, "fail lsb"};
    vecs[2] = '{GOLD ^ 16'h8000, 1'b0, "fail msb"};
    vecs[3] = '{16'h0000,        1'b0, "fail zero"};
    vecs[4] = '{GOLD,            1'b1, "pass again"};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.misr_sig = '0;
`ifdef LBIST_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    build_trace();
    repeat (2) @(negedge clk);
    chk_out("reset state", sample(), '0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("idle without start", sample(), '0);

    foreach (vecs[v]) run_check(vecs[v].sig, vecs[v].exp_go, 1'b0, 1'b0, vecs[v].name);

    for (int r = 0; r < 6; r++) begin
      sig = ($urandom_range(0, 1) == 1) ? GOLD : 16'($urandom);
      run_check(sig, (sig == GOLD), 1'b0, 1'b1, $sformatf("rand%0d", r));
    end

    // START held high: relaunch the cycle after DONE, pass then fail.
    run_check(GOLD, 1'b1, 1'b1, 1'b0, "hold pass");
    run_check(GOLD ^ 16'h0001, 1'b0, 1'b1, 1'b0, "hold fail");
    bus.start = 1'b0;
    @(negedge clk);
    chk_out("done holds", sample(), out_t'(2'b10));

    // Asynchronous reset mid-run.
    run_partial(10, "pre-rst");
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_out("async rst outputs", sample(), '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_out("idle after rst", sample(), '0);
    run_check(GOLD, 1'b1, 1'b0, 1'b0, "after rst");

`ifdef LBIST_SEQ_ABORT_EN
    run_partial(15, "pre-abort");
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk_out("abort to idle", sample(), '0);
    bus.abort = 1'b1;
    repeat (2) @(negedge clk);
    chk_out("abort in idle", sample(), '0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    chk_out("start beats abort", sample(), exp_q[0]);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk_out("abort in load", sample(), '0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lbist_sequencer.md
# lbist_sequencer

Control FSM for the logic-BIST datapath around the core. It sequences the external seed ROM/LFSR, the scan-enable and test-enable controls of the core's scan chains, and the MISR. It runs a fixed seed/pattern schedule, flushes the chains, and compares the final MISR signature against a golden value to produce a GO/NOGO verdict. The block contains only control logic; LFSR, seed storage and MISR stay in the datapath it drives.

## Interface
- SEEDS, 10: number of seeds applied (≥1).
- LOOPS, 200: shift/capture patterns per seed (≥1).
- SCAN_LEN, 24: length of the longest scan chain in shift cycles (≥1).
- MISR_SIZE, 16: signature width.
- MISR_GOLD, 13984: expected final signature.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  level; launches a run when sampled high in IDLE or DONE.
- MISR_SIG  in  MISR_SIZE  current MISR contents.
- LFSR_LOAD  out  1  load seed SEED_IDX into the LFSR this cycle.
- SEED_IDX  out  max(1,$clog2(SEEDS))  seed selector.
- LFSR_EN  out  1  advance the LFSR.
- MISR_CLEAR  out  1  synchronously clear the MISR.
- MISR_EN  out  1  compact DUT outputs into the MISR.
- TEST_MODE  out  1  scan enable to the core (1 = shift, 0 = capture/functional).
- LBIST_EN  out  1  core is under LBIST control.
- TEST_EN  out  1  clock-gate test enable; equal to LBIST_EN.
- BUSY  out  1  run in progress.
- DONE  out  1  run complete, verdict valid.
- GO_NOGO  out  1  1 = signature matched.

## Operation
- States: IDLE, LOAD, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE. Outputs are Moore-decoded from state and counters, except GO_NOGO, which is a register.
- IDLE/DONE: every control output is 0. DONE=1 only in DONE. START=1 → LOAD with seed 0. GO_NOGO is cleared on that same edge.
- LOAD (1 cycle): LFSR_LOAD=1, LBIST_EN=1, TEST_MODE=0. MISR_CLEAR=1 only when SEED_IDX=0. Next state is SHIFT; the shift and loop counters are zeroed.
- SHIFT (SCAN_LEN cycles): TEST_MODE=1, LFSR_EN=1. MISR_EN=1 except during warm-up (seed 0, loop 0), whose unloaded data is functional-mode garbage. After the last shift cycle the next state is CAPTURE.
- CAPTURE (1 cycle): TEST_MODE=0, LFSR_EN=0, MISR_EN=0. The loop counter increments.
  - Loop count < LOOPS → SHIFT.
  - Otherwise, SEED_IDX < SEEDS−1 → SEED_IDX+1, LOAD.
  - Otherwise → UNLOAD.
- UNLOAD (SCAN_LEN cycles): TEST_MODE=1, MISR_EN=1, LFSR_EN=0. This flushes the last capture into the MISR.
- COMPARE (1 cycle): LBIST_EN=1, all other enables 0. GO_NOGO is loaded with (MISR_SIG==MISR_GOLD) on the exit edge. Next state is DONE.
- BUSY=1 in every state except IDLE and DONE.
- START while BUSY is ignored. START held high in DONE immediately re-runs the test.
- SEED_IDX holds during a seed, returns to 0 in IDLE/DONE, and never exceeds SEEDS−1.

## Timing
- Reset values: state IDLE, all counters 0, SEED_IDX=0, all outputs 0 including GO_NOGO and DONE.
- Run length: cycles spent in LOAD through COMPARE = SEEDS·(1+LOOPS·(SCAN_LEN+1)) + SCAN_LEN + 1.
- DONE rises in the cycle after COMPARE. It stays high, with GO_NOGO stable, until the next START or RST.
- RST asserted mid-run forces IDLE and all outputs to 0 immediately, because the reset is asynchronous. No partial verdict is retained.
- SCAN_LEN=1: SHIFT and UNLOAD each last exactly one cycle. LOOPS=1: every seed has one pattern. SEEDS=1: the flow goes CAPTURE → UNLOAD with no second LOAD.
- Counter widths are sized to SCAN_LEN and LOOPS so that the terminal value never wraps.

## Configuration
- LBIST_SEQ_ABORT_EN defined: adds an input ABORT (1 bit).
  - ABORT sampled high in any BUSY state → IDLE on the next edge, all enables 0, GO_NOGO=0, DONE=0.
  - ABORT is ignored in IDLE and DONE.
  - If ABORT and START are both high in IDLE, START wins.
- LBIST_SEQ_ABORT_EN undefined: the ABORT port does not exist, and a run can only be stopped by RST.

## Test plan
- SEEDS=2, LOOPS=3, SCAN_LEN=4, MISR_SIG forced to MISR_GOLD at COMPARE → 37 BUSY cycles, DONE then rises, GO_NOGO=1, exactly 2 LFSR_LOAD pulses with SEED_IDX 0 then 1, MISR_CLEAR exactly once.
- Same configuration, MISR_SIG=MISR_GOLD^1 → DONE=1, GO_NOGO=0.
- Warm-up check → MISR_EN=0 for the first 4 SHIFT cycles only. MISR_EN=1 for the other 20 SHIFT cycles and all 4 UNLOAD cycles. TEST_MODE=0 in all 6 CAPTURE cycles.
- RST pulsed at cycle 10 of a run → all outputs 0 asynchronously. A new START then yields a full 37-cycle run.
- START held high through a run → START is ignored while BUSY, and a second run starts the cycle after DONE. A pass-then-fail sequence shows GO_NOGO cleared at the relaunch.
- With LBIST_SEQ_ABORT_EN, ABORT at cycle 15 → IDLE on the next edge, DONE=0, GO_NOGO=0. ABORT asserted in IDLE → no effect.
